// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline stage register
package pipe_pkg;

  localparam int INSTR_W   = 32;
  localparam int PC_W      = 32;
  localparam int DEF_LANES = 3;
  localparam int DEF_DW    = 32;

  localparam logic [PC_W-1:0] EXC_VECTOR_DEF = 32'hbfc00380;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc8;
    logic               exc;
  } entry_hdr_t;

  typedef struct packed {
    entry_hdr_t                     hdr;
    logic [DEF_LANES*DEF_DW-1:0]    data;
  } entry_t;

  localparam int HDR_W = $bits(entry_hdr_t);

  function automatic entry_hdr_t bubble_hdr(input logic [PC_W-1:0] vec);
    entry_hdr_t h;
    h.instr = '0;
    h.pc    = vec;
    h.pc8   = '0;
    h.exc   = 1'b1;
    return h;
  endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// rtl/pipe_stage_slot.sv - one entry register with valid bit, load and clear
module pipe_stage_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  // clear wins over load so a discarded slot never retains stale payload
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clr) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready stage register with skid entry; optional PIPE_STALL_CNT_EN
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          LANES      = 3,
  parameter int          DW         = 32,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                req,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [31:0]         in_pc,
  input  logic [31:0]         in_pc8,
  input  logic [LANES*DW-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic [31:0]         out_pc,
  output logic [31:0]         out_pc8,
  output logic [LANES*DW-1:0] out_data,
  output logic                out_exc
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [31:0]         perf_stall_cnt
`endif
);

  localparam int DATA_W = LANES * DW;
  localparam int SW     = HDR_W + DATA_W;

  state_e          state, state_n;
  logic            acc, pop;
  logic            main_valid, skid_valid;
  logic [SW-1:0]   main_q, skid_q, main_d, in_ent, bub_ent;
  logic            main_load, main_clr, skid_load, skid_clr;
  entry_hdr_t      in_hdr, main_hdr;

  assign in_hdr  = '{instr: in_instr, pc: in_pc, pc8: in_pc8, exc: 1'b0};
  assign in_ent  = {in_hdr, in_data};
  assign bub_ent = {bubble_hdr(EXC_VECTOR), {DATA_W{1'b0}}};

  // in_ready comes straight from the skid flop, never from out_ready
  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_EMPTY;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (req) begin
      state_n = ST_ONE;
    end else if (flush) begin
      state_n = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (acc) state_n = ST_ONE;
        ST_ONE: begin
          if (acc && !pop)      state_n = ST_TWO;
          else if (!acc && pop) state_n = ST_EMPTY;
        end
        ST_TWO:   if (pop) state_n = ST_ONE;
        default:  state_n = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    main_load = 1'b0;
    main_clr  = 1'b0;
    main_d    = in_ent;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    if (req) begin
      main_load = 1'b1;
      main_d    = bub_ent;
      skid_clr  = 1'b1;
    end else if (flush) begin
      main_clr  = 1'b1;
      skid_clr  = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: main_load = acc;
        ST_ONE: begin
          if (acc && pop)       main_load = 1'b1;
          else if (acc)         skid_load = 1'b1;
          else if (pop)         main_clr  = 1'b1;
        end
        ST_TWO: begin
          if (pop) begin
            main_load = 1'b1;
            main_d    = skid_q;
            skid_clr  = 1'b1;
          end
        end
        default: begin
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  pipe_stage_slot #(.W(SW)) u_main (
    .clk   (clk),
    .reset (reset),
    .clr   (main_clr),
    .load  (main_load),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_q)
  );

  pipe_stage_slot #(.W(SW)) u_skid (
    .clk   (clk),
    .reset (reset),
    .clr   (skid_clr),
    .load  (skid_load),
    .d     (in_ent),
    .valid (skid_valid),
    .q     (skid_q)
  );

  assign main_hdr  = entry_hdr_t'(main_q[SW-1 -: HDR_W]);
  assign out_instr = main_hdr.instr;
  assign out_pc    = main_hdr.pc;
  assign out_pc8   = main_hdr.pc8;
  assign out_exc   = main_hdr.exc;
  assign out_data  = main_q[DATA_W-1:0];

`ifdef PIPE_STALL_CNT_EN
  // saturating; only reset clears it so stall history survives flush and req
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      perf_stall_cnt <= '0;
    else if (out_valid && !out_ready && perf_stall_cnt != 32'hffffffff)
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
  end
`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register for the MIPS core; the successor to the fixed M->W register.
- Carries instr, pc, pc8 and LANES payload lanes of DW bits each.
- Has a valid/ready handshake with a 2-entry skid buffer, so back-pressure does not need a global enable.
- Supports flush, and exception-request insertion of a vectored bubble.
- Instantiated between any two stages (D/E, E/M, M/W).

Parameters:
- LANES, 3, number of data payload lanes (e.g. alu, mdu, cp0).
- DW, 32, width of each payload lane in bits.
- EXC_VECTOR, 32'hbfc00380, pc value loaded into the bubble inserted on req.

Ports:
- clk  in  1  stage clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear; discard all held entries.
- req  in  1  exception request; discard entries and insert the vectored bubble.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept; registered, equals !skid_valid.
- in_instr  in  32  instruction.
- in_pc  in  32  pc.
- in_pc8  in  32  pc+8.
- in_data  in  LANES*DW  lane i at bits [i*DW +: DW].
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts.
- out_instr  out  32  head instruction.
- out_pc  out  32  head pc.
- out_pc8  out  32  head pc8.
- out_data  out  LANES*DW  head payload.
- out_exc  out  1  head entry is an exception bubble.
- perf_stall_cnt  out  32  present only with PIPE_STALL_CNT_EN.

Behaviour:
- Storage:
  - Main entry (drives all out_* ports) and skid entry; each has a valid bit, payload and exc flag.
  - States: EMPTY (no valid entries), ONE (main valid only), TWO (main and skid valid).
- Handshake definitions:
  - acc = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - out_valid = main valid.
- Transitions:
  - EMPTY: acc -> ONE, input loaded into main.
  - ONE, acc & pop -> ONE, main replaced by input.
  - ONE, acc & !pop -> TWO, input into skid.
  - ONE, !acc & pop -> EMPTY.
  - ONE, neither -> hold.
  - TWO: in_ready=0, so acc is impossible. pop -> ONE, skid moves to main, skid cleared. !pop -> hold.
- Latency and throughput:
  - One cycle from acc to out_valid.
  - Full throughput of 1 entry/cycle when out_ready is held high.
  - in_ready depends only on flops; no combinational path from out_ready to in_ready.
- Held data: payload is stable while out_valid & !out_ready; nothing is overwritten until popped.
- flush:
  - Next edge: both valid bits cleared, state EMPTY.
  - An acc in the same cycle is dropped.
  - Payload registers are cleared to 0.
- req:
  - Next edge: skid cleared; main loaded with instr=0, pc=EXC_VECTOR, pc8=0, data=0, exc=1, valid=1; state ONE.
  - Any same-cycle acc or pop is ignored.
  - The bubble is then handled as a normal entry (held until popped).
- Priority: reset > req > flush > normal handshake.
- Reset (asynchronous assert, synchronous-safe deassert by system):
  - out_valid=0, in_ready=1, out_exc=0.
  - out_instr, out_pc, out_pc8 and out_data all 0.
  - State EMPTY.
- Reset mid-operation drops all entries with no further output.
- out_exc is 0 for normally accepted entries and 1 only for req bubbles.

Optional Feature:
- PIPE_STALL_CNT_EN defined:
  - perf_stall_cnt increments on each cycle with out_valid & !out_ready; saturates at 32'hffffffff.
  - Cleared by reset only; flush and req do not clear it.
- Not defined: the port and the counter are absent; no other behaviour change.

Decomposition:
- Package pipe_pkg holds:
  - state enum {ST_EMPTY, ST_ONE, ST_TWO};
  - default EXC_VECTOR constant 32'hbfc00380;
  - a typedef for the entry struct (instr, pc, pc8, data, exc) parametrised via localparam widths.
- One natural sub-module: pipe_stage_slot, a single entry register with load, clear and valid bit, instantiated twice (main and skid).

Test Plan:
- Reset, then in_valid=1 with in_pc=0x00003000, out_ready=1 -> next cycle out_valid=1, out_pc=0x00003000; streaming 4 entries gives 4 consecutive pops.
- Accept A, drop out_ready, present B and C -> B goes to skid, in_ready=0, C is held upstream, out_pc stays A. Raise out_ready -> A, B, C leave in order with none lost.
- State TWO, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, out_data=0, and the flushed inputs never appear.
- Assert req together with flush and in_valid -> next cycle out_valid=1, out_exc=1, out_pc=0xbfc00380, out_instr=0. Bubble held until out_ready=1.
- Drive reset low asynchronously mid-stream (between edges) -> out_valid=0 and in_ready=1 immediately, without waiting for a clock edge.
- With PIPE_STALL_CNT_EN, out_valid=1 and out_ready=0 for 5 cycles -> perf_stall_cnt=5; a flush leaves it at 5.
